// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one frame RAM between scan-out, a pixel writer and a frame clear engine.
// The clear engine is compiled in only when VGA_ARB_CLEAR_EN is defined.
module vga_mem_arbiter #(
    parameter int H_PIX    = 160,
    parameter int V_PIX    = 120,
    parameter int SHIFT    = 2,
    parameter int V_ACTIVE = 480,
    parameter int AW       = 15,
    parameter int DW       = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_tick,
    input  logic          video_on,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          clear_req,
    input  logic [DW-1:0] clear_color,
    output logic          clr_busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rgb,
    output logic          hsync,
    output logic          vsync
);
    localparam int TOTAL = H_PIX * V_PIX;

    logic [9:0]    xs, ys;
    logic          scan, black, run, clr_go, wr_go, wr_ok;
    logic [AW-1:0] scan_addr, clr_addr, addr_d, addr_q;
    logic [DW-1:0] clr_data, wdata_d, wdata_q, rgb_d, rgb_q;
    logic          tick_d, tick_q, vld_d, vld_q, blk_d, blk_q;
    logic [1:0]    hs_d, hs_q, vs_d, vs_q;

    assign xs        = pixel_x >> SHIFT;
    assign ys        = pixel_y >> SHIFT;
    assign scan      = p_tick && video_on;
    assign black     = (xs >= 10'(H_PIX)) || (ys >= 10'(V_PIX));
    assign scan_addr = AW'(ys) * AW'(H_PIX) + AW'(xs);
    assign clr_go    = !scan && run;
    assign wr_go     = !scan && !run && wr_req;
    assign wr_ok     = {1'b0, wr_addr} < (AW+1)'(TOTAL);

`ifdef VGA_ARB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, CLR_WAIT, CLR_RUN} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] col_q, col_d;
    logic          frame_edge, last;

    assign frame_edge = p_tick && pixel_y == 10'(V_ACTIVE) && pixel_x == '0;
    assign last       = cnt_q == AW'(TOTAL - 1);
    assign run        = state_q == CLR_RUN;
    assign clr_busy   = state_q != IDLE;
    assign clr_addr   = cnt_q;
    assign clr_data   = col_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        if (state_q == IDLE && clear_req) begin
            state_d = CLR_WAIT;
            col_d   = clear_color;
        end
        if (state_q == CLR_WAIT && frame_edge) state_d = CLR_RUN;
        if (clr_go) begin
            state_d = last ? IDLE : CLR_RUN;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = ^{clear_req, clear_color};
    assign run        = 1'b0;
    assign clr_busy   = 1'b0;
    assign clr_addr   = '0;
    assign clr_data   = '0;
`endif

    // Scan owns the port on tick cycles; otherwise clear, then writer, else hold the bus.
    always_comb begin
        addr_d  = scan ? scan_addr : clr_go ? clr_addr : wr_go ? wr_addr : addr_q;
        wdata_d = clr_go ? clr_data : wr_go ? wr_data : wdata_q;
        tick_d  = p_tick;
        vld_d   = scan;
        blk_d   = black;
        rgb_d   = tick_q ? ((vld_q && !blk_q) ? mem_rdata : '0) : rgb_q;
        hs_d    = {hs_q[0], hsync_in};
        vs_d    = {vs_q[0], vsync_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            tick_q  <= 1'b0;
            vld_q   <= 1'b0;
            blk_q   <= 1'b0;
            rgb_q   <= '0;
            hs_q    <= '0;
            vs_q    <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tick_q  <= tick_d;
            vld_q   <= vld_d;
            blk_q   <= blk_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign mem_addr  = reset ? '0 : addr_d;
    assign mem_wdata = reset ? '0 : wdata_d;
    assign mem_we    = !reset && (clr_go || (wr_go && wr_ok));
    assign wr_ack    = !reset && wr_go;
    assign rgb       = rgb_q;
    assign hsync     = hs_q[1];
    assign vsync     = vs_q[1];
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: scoreboard bench for vga_mem_arbiter with a behavioural frame RAM.
module tb_vga_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset, p_tick, video_on, hsync_in, vsync_in, wr_req, clear_req;
    logic [9:0]  pixel_x, pixel_y;
    logic [14:0] wr_addr, mem_addr;
    logic [2:0]  wr_data, clear_color, mem_wdata, mem_rdata, rgb;
    logic        wr_ack, clr_busy, mem_we, hsync, vsync;
    int          checks = 0, errors = 0, cyc = 0;
    logic [2:0]  ram     [0:32767];
    logic [2:0]  exp_mem [0:32767];

    typedef struct {int due; logic [2:0] rgb; logic hs; logic vs;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    vga_mem_arbiter dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clear_req(clear_req), .clear_color(clear_color), .clr_busy(clr_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rgb(rgb), .hsync(hsync), .vsync(vsync)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rgb", rgb, e.rgb);
            check("hsync", hsync, e.hs);
            check("vsync", vsync, e.vs);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        p_tick = 0; video_on = 0; wr_req = 0; clear_req = 0;
        repeat (n) tick();
    endtask

    task automatic do_write(input logic [14:0] a, input logic [2:0] d);
        wr_req = 1; wr_addr = a; wr_data = d; p_tick = 0;
        @(negedge clk);
        check("wr_ack", wr_ack, 1);
        check("wr_we", mem_we, a < 19200);
        if (a < 19200) begin
            check("wr_addr", mem_addr, a);
            check("wr_data", mem_wdata, d);
            exp_mem[a] = d;
        end
        tick();
        wr_req = 0;
    endtask

    task automatic scan(input int x, input int y, input logic von, input logic hs, input logic vs);
        exp_t e;
        p_tick = 1; video_on = von; pixel_x = 10'(x); pixel_y = 10'(y);
        hsync_in = hs; vsync_in = vs;
        @(negedge clk);
        if (von) begin
            check("scan_addr", mem_addr, ((y >> 2) * 160 + (x >> 2)) & 32'h7fff);
            check("scan_we", mem_we, 0);
        end
        e.due = cyc + 2;
        e.rgb = (von && (x >> 2) < 160 && (y >> 2) < 120) ? exp_mem[(y >> 2) * 160 + (x >> 2)] : 3'd0;
        e.hs = hs;
        e.vs = vs;
        sb.push_back(e);
        tick();
        p_tick = 0; video_on = 0; hsync_in = !hs; vsync_in = !vs;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i] = 3'd0;
            exp_mem[i] = 3'd0;
        end
        ram[19200] = 3'd6;
        reset = 1; p_tick = 1; video_on = 1; pixel_x = 8; pixel_y = 4;
        hsync_in = 1; vsync_in = 1; wr_req = 1; wr_addr = 5; wr_data = 3'b101;
        clear_req = 0; clear_color = 0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_outs", {rgb, hsync, vsync, wr_ack, mem_we, clr_busy}, 0);
        check("rst_bus", {mem_addr, mem_wdata}, 0);
        tick();
        reset = 0; hsync_in = 0; vsync_in = 0;
        do_write(5, 3'b101);
        do_write(162, 3'b011);
        do_write(160, 3'b111);
        do_write(33, 3'b100);

        scan(8, 4, 1, 1, 0);
        tick();
        @(negedge clk);
        check("rgb_hold", rgb, 3'b011);
        tick();
        scan(20, 0, 1, 0, 1);
        scan(132, 0, 1, 1, 1);
        scan(640, 0, 1, 0, 0);
        scan(0, 480, 1, 1, 0);
        scan(8, 4, 0, 0, 1);
        idle(2);

        wr_req = 1; wr_addr = 15'd19200; wr_data = 3'd1; p_tick = 1; video_on = 1; pixel_x = 0; pixel_y = 0;
        @(negedge clk);
        check("stall_ack", {wr_ack, mem_we}, 0);
        tick();
        p_tick = 0; video_on = 0;
        @(negedge clk);
        check("drop_ack", {wr_ack, mem_we}, 2'b10);
        tick();
        wr_addr = 7; wr_data = 2; p_tick = 1; video_on = 0;
        @(negedge clk);
        check("blank_ack", {wr_ack, mem_we, mem_addr}, {2'b11, 15'd7});
        tick();
        exp_mem[7] = 2;
        idle(0);
        @(negedge clk);
        check("hold_addr", {mem_we, mem_addr}, {1'b0, 15'd7});
        tick();

`ifdef VGA_ARB_CLEAR_EN
        clear_req = 1; clear_color = 3'b111; p_tick = 1; pixel_y = 480; pixel_x = 0;
        @(negedge clk);
        check("clr_busy_pre", clr_busy, 0);
        tick();
        clear_req = 0; clear_color = 0; p_tick = 0; pixel_y = 0;
        @(negedge clk);
        check("clr_busy_wait", clr_busy, 1);
        tick();
        do_write(40, 3'b010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wait_we", mem_we, 0);
            tick();
        end
        p_tick = 1; pixel_y = 480; pixel_x = 0;
        @(negedge clk);
        check("edge_we", mem_we, 0);
        tick();
        pixel_y = 0;
        begin
            int n;
            n = 0;
            wr_req = 1; wr_addr = 33; wr_data = 3'b001;
            for (int c = 0; c < 40000 && n < 19200 && errors < 20; c++) begin
                p_tick = c[0]; video_on = c < 40;
                @(negedge clk);
                if (p_tick && video_on) check("run_scan", {mem_we, wr_ack}, 0);
                else begin
                    check("run_wr", {mem_we, wr_ack, mem_addr, mem_wdata}, {2'b10, 15'(n), 3'd7});
                    n++;
                end
                tick();
            end
            check("run_count", n, 19200);
        end
        p_tick = 0; video_on = 0;
        @(negedge clk);
        check("clr_done", clr_busy, 0);
        check("post_ack", {wr_ack, mem_we, mem_addr}, {2'b11, 15'd33});
        tick();
        wr_req = 0;
        for (int i = 0; i < 19200; i++) exp_mem[i] = 3'd7;
        exp_mem[33] = 3'b001;
        scan(8, 4, 1, 0, 0);
        scan(132, 0, 1, 1, 0);

        clear_req = 1; clear_color = 3'b010;
        tick();
        clear_req = 0; p_tick = 1; pixel_y = 480; pixel_x = 0;
        tick();
        p_tick = 0; pixel_y = 0;
        repeat (100) tick();
        reset = 1;
        @(negedge clk);
        check("rst_run_we", mem_we, 0);
        tick();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_run", {mem_we, clr_busy}, 0);
            tick();
        end
        for (int i = 0; i < 100; i++) exp_mem[i] = 3'b010;
        scan(0, 0, 1, 0, 0);
        scan(396, 0, 1, 0, 0);
        scan(400, 0, 1, 0, 0);
        do_write(41, 3'b110);
`else
        clear_req = 1; clear_color = 3'b101;
        tick();
        clear_req = 0;
        @(negedge clk);
        check("no_clr_busy", clr_busy, 0);
        tick();
        p_tick = 1; pixel_y = 480; pixel_x = 0;
        tick();
        p_tick = 0; pixel_y = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_clr_we", {mem_we, clr_busy}, 0);
            tick();
        end
        do_write(60, 3'b110);
        scan(240, 0, 1, 1, 0);
        scan(0, 0, 1, 0, 1);
`endif
        idle(4);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Shares one single-port synchronous frame memory between VGA scan-out and a pixel writer, and sequences a whole-frame clear engine. Sits between `vga_sync` (timing source) and the frame RAM. Emits registered RGB and pipeline-aligned sync to the DAC pins. Scan-out reads always win; writer and clear traffic use the remaining memory cycles.

## Interface
Parameters:
- `H_PIX`, 160: frame-buffer width in pixels.
- `V_PIX`, 120: frame-buffer height in pixels.
- `SHIFT`, 2: log2 of the screen-to-buffer scale (640x480 to 160x120).
- `V_ACTIVE`, 480: first non-visible line; marks the frame boundary.
- `AW`, 15: memory address width.
- `DW`, 3: pixel width (RGB, 1 bit each).

Ports:
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: synchronous, active-high.
- `p_tick` in 1: pixel-rate enable from `vga_sync`.
- `video_on` in 1: active-area flag from `vga_sync`.
- `pixel_x`, `pixel_y` in 10 each: current screen coordinates.
- `hsync_in`, `vsync_in` in 1 each: sync from `vga_sync`.
- `wr_req` in 1: writer request; `wr_addr` and `wr_data` are held until ack.
- `wr_addr` in AW: writer pixel address.
- `wr_data` in DW: writer pixel value.
- `wr_ack` out 1: one-cycle pulse when the write is accepted.
- `clear_req` in 1: request a full-buffer clear.
- `clear_color` in DW: clear value, latched when the clear is accepted.
- `clr_busy` out 1: a clear is pending or running.
- `mem_addr` out AW: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out DW: RAM write data.
- `mem_rdata` in DW: RAM read data, valid 1 cycle after the address.
- `rgb` out DW: pixel to DAC.
- `hsync`, `vsync` out 1 each: sync delayed to match `rgb`.

## Operation
- Scan slot: any cycle with `p_tick && video_on`.
  - `mem_addr = (pixel_y>>SHIFT)*H_PIX + (pixel_x>>SHIFT)`.
  - `mem_we = 0`.
  - If `(pixel_x>>SHIFT) >= H_PIX` or `(pixel_y>>SHIFT) >= V_PIX`, the pixel is flagged black.
- Every other cycle is a free slot. Free-slot priority: clear engine in `CLR_RUN`, then writer, then idle. When idle, `mem_we = 0` and `mem_addr` holds its last value.
- Writer grant:
  - Granted in a free slot when `wr_req` is high and the FSM is not in `CLR_RUN`.
  - `wr_ack` pulses for that cycle.
  - If `wr_addr >= H_PIX*V_PIX`, the write is acked but `mem_we` stays 0 (dropped).
- Clear FSM (`IDLE`, `CLR_WAIT`, `CLR_RUN`):
  - `IDLE` to `CLR_WAIT`: on `clear_req`. `clear_color` is latched; `clr_busy` goes to 1.
  - `CLR_WAIT` to `CLR_RUN`: at the frame boundary, defined as `p_tick && pixel_y==V_ACTIVE && pixel_x==0`.
  - `CLR_RUN`: each free slot writes the latched colour at `clr_cnt`, then increments it.
  - After writing `H_PIX*V_PIX-1`, the FSM returns to `IDLE`, `clr_cnt` goes to 0, and `clr_busy` goes to 0 on the next edge.
  - `clear_req` is ignored outside `IDLE`.
- Writers stall (no ack) during `CLR_RUN` only. During `CLR_WAIT` they are still served.
- Output stage: `rgb = (scan-slot-valid && !black) ? mem_rdata : 0`. The scan-slot-valid and black flags are delayed one stage to meet `mem_rdata`. `rgb` holds its value between pixel ticks.
- Arithmetic: the address product is computed at AW bits. `H_PIX*V_PIX` must not exceed 2^AW.

## Timing
- Reset values:
  - `rgb`, `hsync`, `vsync`, `wr_ack`, `mem_we`, `clr_busy` are 0.
  - `mem_addr` and `mem_wdata` are 0.
  - FSM is `IDLE`; `clr_cnt` is 0.
  - The delay pipeline is cleared.
- Reset mid-clear: abandons the clear immediately. No further clear writes occur after the reset edge.
- Scan latency:
  - Address is driven in the p_tick cycle; `mem_rdata` arrives the next cycle.
  - `rgb` is registered at the edge after that, i.e. 2 clocks after the p_tick cycle.
  - `hsync` and `vsync` are `hsync_in`/`vsync_in` delayed by exactly 2 clocks.
- Writer handshake: `wr_ack` is asserted in the same cycle `mem_we` writes that data. The writer may change `wr_addr`/`wr_data` or drop `wr_req` on the following edge.
- Simultaneous events:
  - Scan slot together with `wr_req`: scan wins; the writer is acked at the next free slot.
  - `clear_req` together with the frame boundary while in `IDLE`: goes to `CLR_WAIT` only. The run starts at the next frame boundary.
- Worst-case writer wait during `video_on` is 1 cycle, since p_tick is high every other cycle.

## Configuration
- `VGA_ARB_CLEAR_EN` defined: clear FSM, `clr_cnt` and the latched colour are compiled in.
- Not defined:
  - `clear_req` and `clear_color` are ignored; `clr_busy` is tied 0.
  - The writer is never stalled.
  - All other behaviour is unchanged.

## Test plan
- Reset mid-frame: all outputs 0 after the reset edge. `wr_req=1` with `wr_addr=5`, `wr_data=3'b101` gives `wr_ack` in the first free cycle, with `mem_we=1`, `mem_addr=5`, `mem_wdata=5`.
- Scan at `pixel_x=8`, `pixel_y=4`, `video_on=1`: `mem_addr=162`, `mem_we=0`. With `mem_rdata=3'b011` the next cycle, `rgb=3'b011` two clocks after p_tick, and `hsync` matches `hsync_in` from 2 clocks earlier.
- `wr_req` held through a scan slot: no ack in the p_tick cycle, ack in the following cycle; `wr_addr=19200` is acked with `mem_we=0`.
- `clear_req` with `clear_color=3'b111`: `clr_busy=1`, no clear writes until `pixel_y=480, pixel_x=0`. Then writes cover addresses 0..19199 in order, writer acks are suppressed, and `clr_busy` falls after address 19199.
- `reset` asserted during `CLR_RUN` at `clr_cnt=100`: no further clear writes, `clr_busy=0`, FSM in `IDLE`.
- Build without `VGA_ARB_CLEAR_EN`: `clear_req` pulse gives `clr_busy=0` and the writer is acked normally.
